// File: rtl/img_frame_packer.sv
// Packs an RGB565 pixel stream into 32-bit host words: one RGB888 word per
// pixel, two raw pixels per word, or one word per pixel after a SYNC_WORD header.
module img_frame_packer #(
  parameter int          IMG_WIDTH  = 640,
  parameter int          IMG_HEIGHT = 480,
  parameter logic [31:0] SYNC_WORD  = 32'hFF000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sync,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] frame_count,
  output logic        err_short
);

  localparam int          TOTAL    = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [19:0] LAST_IDX = 20'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PIXELS
  } state_t;

  state_t      state;
  logic [1:0]  mode_q;
  logic [19:0] pix_cnt;
  logic [15:0] half_p0;
  logic        half_vld_p0;

  logic        out_free;
  logic        in_fire;
  logic        sync_fire;
  logic        pix_fire;
  logic        last_pix;
  logic [1:0]  new_mode;

  function automatic logic [31:0] expand565(input logic [15:0] p);
    return {8'h00, p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

  // Reserved mode 3 behaves exactly like mode 0.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'd3) ? 2'd0 : m;
  endfunction

  assign out_free  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign sync_fire = in_fire && in_sync;
  assign pix_fire  = in_fire && !in_sync && (state == PIXELS);
  assign last_pix  = (pix_cnt == LAST_IDX);
  assign new_mode  = eff_mode(mode);

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      HEADER:  in_ready = 1'b0;
      default: in_ready = out_free;
    endcase
  end

  // Output stage: a single register that also accepts a new word in the
  // same cycle the current one is taken, so modes 0/2 sustain one pixel/cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= 2'd0;
      pix_cnt     <= 20'd0;
      half_p0     <= 16'd0;
      half_vld_p0 <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 32'd0;
      out_last    <= 1'b0;
      frame_count <= 16'd0;
      err_short   <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (sync_fire) begin
        // A sync mid-frame abandons the partial frame but leaves any word
        // already sitting in the output register untouched.
        if (state == PIXELS)
          err_short <= 1'b1;
        mode_q      <= new_mode;
        pix_cnt     <= 20'd0;
        half_vld_p0 <= 1'b0;
        state       <= (new_mode == 2'd2) ? HEADER : PIXELS;
      end else begin
        case (state)
          HEADER: begin
            if (out_free) begin
              out_valid <= 1'b1;
              out_data  <= SYNC_WORD;
              out_last  <= 1'b0;
              state     <= PIXELS;
            end
          end
          PIXELS: begin
            if (pix_fire) begin
              if (mode_q == 2'd1 && !half_vld_p0) begin
                half_p0     <= in_data;
                half_vld_p0 <= 1'b1;
              end else begin
                out_valid   <= 1'b1;
                out_last    <= last_pix;
                out_data    <= (mode_q == 2'd1) ? {in_data, half_p0} : expand565(in_data);
                half_vld_p0 <= 1'b0;
              end
              if (last_pix) begin
                pix_cnt     <= 20'd0;
                frame_count <= frame_count + 16'd1;
                state       <= IDLE;
              end else begin
                pix_cnt <= pix_cnt + 20'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
